// File: rtl/trace_dump_scheduler.sv
// -----------------------------------------------------------------------------
// trace_dump_scheduler
//
// Shares one AXI write flusher between NUM_BUF trace-capture BRAMs. Dump
// requests are latched into a pending vector, granted round-robin, and the
// flusher's BRAM read port is muxed onto the granted buffer. For each grant
// the flusher receives base_ptr = host_base + idx*BUF_STRIDE and a one-cycle
// start pulse; completion is detected from the flusher's idle flag.
//
// Ports
//   aclk, aresetn   clock, synchronous active-low reset
//   host_base       byte address of buffer 0 region, sampled at grant
//   req             per-buffer one-cycle dump request
//   done            per-buffer one-cycle "written to host" pulse
//   busy            high whenever the scheduler is not idle
//   grant_idx       buffer currently (or most recently) granted
//   dump_count      completed dumps since reset (wraps at 2^32)
//   fl_base_ptr     flusher base pointer
//   fl_start        flusher start_dump pulse
//   fl_idle         flusher dump_idle
//   fl_addra/fl_ena flusher BRAM read address / enable
//   fl_douta        read data returned to the flusher
//   bram_addr       address broadcast to every buffer
//   bram_en         per-buffer read enable
//   bram_dout       concatenated per-buffer read data, slice i = buffer i
// -----------------------------------------------------------------------------
module trace_dump_scheduler #(
    parameter int NUM_BUF         = 4,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 12,
    parameter int BUF_STRIDE      = 8192
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [63:0]                          host_base,
    input  logic [NUM_BUF-1:0]                   req,
    output logic [NUM_BUF-1:0]                   done,
    output logic                                 busy,
    output logic [$clog2(NUM_BUF)-1:0]           grant_idx,
    output logic [31:0]                          dump_count,
    output logic [63:0]                          fl_base_ptr,
    output logic                                 fl_start,
    input  logic                                 fl_idle,
    input  logic [BRAM_ADDR_WIDTH-1:0]           fl_addra,
    input  logic                                 fl_ena,
    output logic [BRAM_DATA_WIDTH-1:0]           fl_douta,
    output logic [BRAM_ADDR_WIDTH-1:0]           bram_addr,
    output logic [NUM_BUF-1:0]                   bram_en,
    input  logic [NUM_BUF*BRAM_DATA_WIDTH-1:0]   bram_dout
);

    localparam int          IDX_W     = $clog2(NUM_BUF);
    localparam logic [63:0] STRIDE_64 = 64'(BUF_STRIDE);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_IDLE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [NUM_BUF-1:0]   pending_r;
    logic [NUM_BUF-1:0]   pending_nxt_s;
    // Set when the granted buffer is requested again while its dump runs;
    // keeps its pending bit alive through DONE so a fresh dump follows.
    logic                 rereq_r;
    logic                 rereq_nxt_s;
    logic [IDX_W-1:0]     grant_idx_r;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [63:0]          fl_base_ptr_r;
    logic                 fl_start_r;
    logic [NUM_BUF-1:0]   done_r;
    logic                 busy_r;
    logic [31:0]          dump_count_r;
    logic [IDX_W:0]       pick_s;
    logic                 pick_valid_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [NUM_BUF-1:0]   bram_en_s;
    logic [BRAM_DATA_WIDTH-1:0] fl_douta_s;

    // First set bit of vec searching upward from start, wrapping at NUM_BUF.
    // Result is {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_BUF-1:0] vec,
                                               input logic [IDX_W-1:0]   start);
        logic             found;
        logic             hit;
        logic [IDX_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_BUF; k++) begin
            j     = int'(start) + k;
            j     = (j >= NUM_BUF) ? (j - NUM_BUF) : j;
            hit   = vec[IDX_W'(j)] & ~found;
            idx   = hit ? IDX_W'(j) : idx;
            found = found | hit;
        end
        return {found, idx};
    endfunction

    // Round-robin arbitration over the pending vector.
    always_comb begin
        pick_s       = rr_pick(pending_r, rr_ptr_r);
        pick_valid_s = pick_s[IDX_W];
        pick_idx_s   = pick_s[IDX_W-1:0];
    end

    // Dump sequencing FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = S_START;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                state_nxt_s = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!fl_idle) begin
                    state_nxt_s = S_WAIT_IDLE;
                end else begin
                    state_nxt_s = S_WAIT_BUSY;
                end
            end
            S_WAIT_IDLE: begin
                if (fl_idle) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_WAIT_IDLE;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Pending vector: new requests always win over the DONE-time clear.
    always_comb begin
        pending_nxt_s = pending_r;
        if (state_r == S_DONE) begin
            pending_nxt_s[grant_idx_r] = rereq_r;
        end else begin
            pending_nxt_s = pending_r;
        end
        pending_nxt_s = pending_nxt_s | req;
    end

    // Re-request tracking for the buffer currently being dumped.
    always_comb begin
        rereq_nxt_s = rereq_r;
        if (state_r == S_IDLE) begin
            rereq_nxt_s = 1'b0;
        end else if (req[grant_idx_r]) begin
            rereq_nxt_s = 1'b1;
        end else begin
            rereq_nxt_s = rereq_r;
        end
    end

    // Registered state, grant bookkeeping and flusher-facing outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r       <= S_IDLE;
            pending_r     <= {NUM_BUF{1'b0}};
            rereq_r       <= 1'b0;
            grant_idx_r   <= {IDX_W{1'b0}};
            rr_ptr_r      <= {IDX_W{1'b0}};
            fl_base_ptr_r <= 64'd0;
            fl_start_r    <= 1'b0;
            done_r        <= {NUM_BUF{1'b0}};
            busy_r        <= 1'b0;
            dump_count_r  <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            pending_r  <= pending_nxt_s;
            rereq_r    <= rereq_nxt_s;
            busy_r     <= (state_nxt_s != S_IDLE);
            fl_start_r <= (state_r == S_START);
            if ((state_r == S_IDLE) && pick_valid_s) begin
                grant_idx_r   <= pick_idx_s;
                fl_base_ptr_r <= host_base + (64'(pick_idx_s) * STRIDE_64);
            end
            // done and dump_count are registered on entry so they are
            // visible during the DONE cycle itself.
            if ((state_r == S_WAIT_IDLE) && fl_idle) begin
                done_r       <= {{(NUM_BUF-1){1'b0}}, 1'b1} << grant_idx_r;
                dump_count_r <= dump_count_r + 32'd1;
            end else begin
                done_r       <= {NUM_BUF{1'b0}};
            end
            if (state_r == S_DONE) begin
                rr_ptr_r <= (grant_idx_r == IDX_W'(NUM_BUF - 1)) ?
                            {IDX_W{1'b0}} : (grant_idx_r + IDX_W'(1));
            end
        end
    end

    // BRAM read-port mux: only the granted buffer sees enable, only while busy.
    always_comb begin
        bram_en_s  = {NUM_BUF{1'b0}};
        fl_douta_s = {BRAM_DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_BUF; i++) begin
            bram_en_s[i] = fl_ena & busy_r & (grant_idx_r == IDX_W'(i));
            fl_douta_s   = (grant_idx_r == IDX_W'(i)) ?
                           bram_dout[i*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH] : fl_douta_s;
        end
    end

    assign done        = done_r;
    assign busy        = busy_r;
    assign grant_idx   = grant_idx_r;
    assign dump_count  = dump_count_r;
    assign fl_base_ptr = fl_base_ptr_r;
    assign fl_start    = fl_start_r;
    assign bram_addr   = fl_addra;
    assign bram_en     = bram_en_s;
    assign fl_douta    = fl_douta_s;

endmodule

// File: tb/tb_trace_dump_scheduler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for trace_dump_scheduler (NUM_BUF=4, DW=32, AW=12).
// A small flusher model answers fl_start with configurable latency; the
// expected grant order is derived from round-robin rules over request masks.
// -----------------------------------------------------------------------------
module tb_trace_dump_scheduler;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [63:0]  host_base;
    logic [3:0]   req;
    logic [3:0]   done;
    logic         busy;
    logic [1:0]   grant_idx;
    logic [31:0]  dump_count;
    logic [63:0]  fl_base_ptr;
    logic         fl_start;
    logic         fl_idle;
    logic [11:0]  fl_addra;
    logic         fl_ena;
    logic [31:0]  fl_douta;
    logic [11:0]  bram_addr;
    logic [3:0]   bram_en;
    logic [127:0] bram_dout;

    int          errors = 0;
    int          checks = 0;
    int          fl_pre = 1;
    int          fl_run = 4;
    int          model_rr = 0;
    int          exp_cnt = 0;
    logic [63:0] cur_hb;
    logic [63:0] exp_base;

    trace_dump_scheduler dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .host_base   (host_base),
        .req         (req),
        .done        (done),
        .busy        (busy),
        .grant_idx   (grant_idx),
        .dump_count  (dump_count),
        .fl_base_ptr (fl_base_ptr),
        .fl_start    (fl_start),
        .fl_idle     (fl_idle),
        .fl_addra    (fl_addra),
        .fl_ena      (fl_ena),
        .fl_douta    (fl_douta),
        .bram_addr   (bram_addr),
        .bram_en     (bram_en),
        .bram_dout   (bram_dout)
    );

    always #5 aclk = ~aclk;

    // Flusher model: reacts 1 time unit after each edge, shares the reset.
    initial begin
        int phase;
        int cnt;
        phase    = 0;
        cnt      = 0;
        fl_idle  = 1'b1;
        fl_ena   = 1'b0;
        fl_addra = 12'd0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                phase = 0; fl_idle = 1'b1; fl_ena = 1'b0;
            end else begin
                case (phase)
                    0: if (fl_start) begin phase = 1; cnt = fl_pre; end
                    1: begin
                        if (cnt == 0) begin fl_idle = 1'b0; phase = 2; cnt = fl_run; end
                        else cnt--;
                    end
                    default: begin
                        fl_ena   = 1'($urandom_range(0, 1));
                        fl_addra = 12'($urandom);
                        if (cnt == 0) begin fl_idle = 1'b1; fl_ena = 1'b0; phase = 0; end
                        else cnt--;
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #3;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn  = 1'b1;
        model_rr = 0;
        exp_cnt  = 0;
    endtask

    // Wait for the start pulse of buffer idx; then move host_base elsewhere.
    task automatic wait_start(input int idx);
        int n;
        n = 0;
        while (fl_start !== 1'b1 && n < 60) begin tick(); n++; end
        chk("start_seen", 64'(fl_start), 64'd1);
        chk("grant_idx", 64'(grant_idx), 64'(idx));
        exp_base = cur_hb + 64'(idx) * 64'd8192;
        chk("base_ptr", fl_base_ptr, exp_base);
        host_base = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) host_base[63:16] = 48'hFFFF_FFFF_FFFF;
        cur_hb = host_base;
    endtask

    task automatic wait_done(input int idx);
        int n;
        n = 0;
        while (done === 4'b0000 && n < 300) begin tick(); n++; end
        exp_cnt++;
        chk("done_vec", 64'(done), 64'(4'b0001 << idx));
        chk("dump_count", 64'(dump_count), 64'(exp_cnt));
        chk("base_hold", fl_base_ptr, exp_base);
        model_rr = (idx + 1) % 4;
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    // Serve a request mask; expected order is a circular scan from model_rr.
    task automatic serve_mask(input logic [3:0] m, input bit allow_rereq);
        int q[$];
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (model_rr + k) % 4;
            if (m[i]) q.push_back(i);
        end
        req = m;
        tick();
        req = 4'b0000;
        while (q.size() > 0) begin
            i = q.pop_front();
            wait_start(i);
            if (allow_rereq && $urandom_range(0, 2) == 0) begin
                req = 4'b0001 << i;
                tick();
                req = 4'b0000;
                q.push_back(i);
            end
            wait_done(i);
        end
    endtask

    initial begin
        int n;
        bit seen_low;
        bit saw;
        aresetn   = 1'b0;
        host_base = 64'd0;
        cur_hb    = 64'd0;
        exp_base  = 64'd0;
        req       = 4'b0000;
        bram_dout = 128'd0;
        do_reset();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_start", 64'(fl_start), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
        chk("rst_count", 64'(dump_count), 64'd0);
        chk("rst_base", fl_base_ptr, 64'd0);
        chk("rst_bram_en", 64'(bram_en), 64'd0);

        // Test 1: single req[2], exact latency
        fl_pre = 1; fl_run = 4;
        host_base = 64'h1000_0000; cur_hb = host_base;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("t1_pend_start", 64'(fl_start), 64'd0);
        chk("t1_pend_busy", 64'(busy), 64'd0);
        tick();
        chk("t1_grant_busy", 64'(busy), 64'd1);
        chk("t1_grant_start", 64'(fl_start), 64'd0);
        tick();
        chk("t1_start", 64'(fl_start), 64'd1);
        chk("t1_grant_idx", 64'(grant_idx), 64'd2);
        chk("t1_base", fl_base_ptr, 64'h1000_4000);
        tick();
        chk("t1_start_pulse", 64'(fl_start), 64'd0);
        n = 0; seen_low = 1'b0;
        while (!(seen_low && fl_idle) && n < 100) begin
            if (!fl_idle) seen_low = 1'b1;
            tick(); n++;
        end
        chk("t1_idle_rose", 64'(fl_idle && seen_low), 64'd1);
        chk("t1_done_early", 64'(done), 64'd0);
        tick();
        chk("t1_done", 64'(done), 64'(4'b0100));
        chk("t1_count", 64'(dump_count), 64'd1);
        tick();
        chk("t1_done_clr", 64'(done), 64'd0);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // Test 2: all four at once after reset -> 0,1,2,3
        do_reset();
        fl_pre = 0; fl_run = 2;
        serve_mask(4'b1111, 1'b0);

        // Test 3: after buffer 1, req[0]+req[3] -> 3 before 0
        serve_mask(4'b0010, 1'b0);
        host_base = 64'hFFFF_FFFF_FFFF_C000; cur_hb = host_base;
        serve_mask(4'b1001, 1'b0);

        // Test 4: triple re-request during own dump -> exactly one extra dump
        fl_pre = 0; fl_run = 12;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        wait_start(1);
        repeat (3) begin
            req = 4'b0010; tick();
            req = 4'b0000; tick();
        end
        wait_done(1);
        wait_start(1);
        wait_done(1);
        saw = 1'b0;
        repeat (15) begin tick(); saw = saw | fl_start | busy; end
        chk("t4_no_third", 64'(saw), 64'd0);

        // Test 5: BRAM mux during dump of buffer 2
        fl_pre = 0; fl_run = 15;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        wait_start(2);
        repeat (10) begin
            tick();
            bram_dout = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("t5_bram_en", 64'(bram_en), fl_ena ? 64'(4'b0100) : 64'd0);
            chk("t5_douta", 64'(fl_douta), 64'(bram_dout[95:64]));
            chk("t5_addr", 64'(bram_addr), 64'(fl_addra));
        end
        wait_done(2);

        // Test 6: reset while waiting for the flusher to go idle
        fl_pre = 0; fl_run = 20;
        req = 4'b1000;
        tick();
        req = 4'b0000;
        n = 0;
        while (fl_idle !== 1'b0 && n < 30) begin tick(); n++; end
        chk("t6_flusher_busy", 64'(fl_idle), 64'd0);
        tick();
        tick();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        model_rr = 0; exp_cnt = 0;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_count", 64'(dump_count), 64'd0);
        chk("t6_base", fl_base_ptr, 64'd0);
        saw = 1'b0;
        repeat (10) begin tick(); saw = saw | busy | (|done) | fl_start; end
        chk("t6_quiet", 64'(saw), 64'd0);
        fl_run = 3;
        serve_mask(4'b0010, 1'b0);

        // Randomized rounds against the round-robin model
        for (int r = 0; r < 15; r++) begin
            fl_pre = $urandom_range(0, 3);
            fl_run = $urandom_range(0, 8);
            serve_mask(4'($urandom_range(1, 15)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
